// File: rtl/mx_pkg.sv
// Shared constants and state type for the MX shared-scale decode path.
package mx_pkg;

  localparam int MX_SCALE_W    = 8;
  localparam int MX_SCALE_BIAS = 127;

  // E8M0 reserves the all-ones encoding for NaN
  localparam logic [MX_SCALE_W-1:0] E8M0_NAN = '1;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } mx_state_e;

endpackage

// File: rtl/mx_exp_restore.sv
// Restores one element's absolute exponent from its field and the block scale.
// Zero fields, underflow and overflow are clamped into the output range.
module mx_exp_restore
  import mx_pkg::*;
#(
  parameter int scale_width = MX_SCALE_W,
  parameter int scale_bias  = MX_SCALE_BIAS,
  parameter int elem_width  = 4,
  parameter int out_width   = 8
) (
  input  logic [elem_width-1:0]  i_elem,
  input  logic [scale_width-1:0] i_scale,
  output logic [out_width-1:0]   o_exp
);

  localparam int SUM_W   = ((scale_width > elem_width) ? scale_width : elem_width) + 2;
  localparam int OUT_MAX = (1 << out_width) - 1;

  function automatic logic [out_width-1:0] clamp_exp(input logic signed [SUM_W-1:0] s);
    int sx;
    sx = int'(s);
    if (sx <= 0)            return '0;
    else if (sx > OUT_MAX)  return '1;
    else                    return out_width'(sx);
  endfunction

  logic signed [SUM_W-1:0] sum;

  always_comb begin
    sum   = $signed(SUM_W'(i_elem)) + $signed(SUM_W'(i_scale)) - $signed(SUM_W'(scale_bias));
    // a zero field encodes zero/subnormal and must stay zero whatever the scale
    o_exp = (i_elem == '0) ? '0 : clamp_exp(sum);
  end

endmodule

// File: rtl/mx_scale_expand.sv
// MX block decoder: buffers one block and streams restored exponents lanes per beat.
// Optional macro MX_NAN_SCALE_EN flags an all-ones (E8M0 NaN) scale and forces all-ones outputs.
module mx_scale_expand
  import mx_pkg::*;
#(
  parameter int scale_width = MX_SCALE_W,
  parameter int scale_bias  = MX_SCALE_BIAS,
  parameter int elem_width  = 4,
  parameter int out_width   = 8,
  parameter int length      = 32,
  parameter int lanes       = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_valid,
  output logic                                o_ready,
  input  logic [scale_width-1:0]              i_scale,
  input  logic [length-1:0][elem_width-1:0]   i_exps,
  output logic                                o_valid,
  input  logic                                i_ready,
  output logic [lanes-1:0][out_width-1:0]     o_exps,
  output logic                                o_last,
  output logic                                o_nan
);

  localparam int            BEATS     = length / lanes;
  localparam int            BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  mx_state_e                                   state_q, state_d;
  logic [BW-1:0]                               beat_q, beat_d;
  logic [scale_width-1:0]                      scale_q, scale_d;
  logic [BEATS-1:0][lanes-1:0][elem_width-1:0] buf_q, buf_d;
  logic                                        is_last, ready, accept;
  logic [lanes-1:0][out_width-1:0]             restored;
  logic                                        nan_blk;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    scale_d = scale_q;
    buf_d   = buf_q;
    is_last = (state_q == STREAM) && (beat_q == LAST_BEAT);
    // reloading on the last handshake keeps back-to-back blocks bubble-free
    ready   = (state_q == IDLE) || (is_last && i_ready);
    accept  = i_valid && ready;
    if (accept) begin
      state_d = STREAM;
      beat_d  = '0;
      scale_d = i_scale;
      buf_d   = i_exps;
    end else if ((state_q == STREAM) && i_ready) begin
      if (is_last) begin
        state_d = IDLE;
        beat_d  = '0;
      end else begin
        beat_d  = beat_q + BW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      scale_q <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      scale_q <= scale_d;
      buf_q   <= buf_d;
    end
  end

  // registered buffer -> per-lane restore (no path from i_exps)
  for (genvar k = 0; k < lanes; k++) begin : g_lane
    mx_exp_restore #(
      .scale_width (scale_width),
      .scale_bias  (scale_bias),
      .elem_width  (elem_width),
      .out_width   (out_width)
    ) u_restore (
      .i_elem  (buf_q[beat_q][k]),
      .i_scale (scale_q),
      .o_exp   (restored[k])
    );
  end

`ifdef MX_NAN_SCALE_EN
  assign nan_blk = (scale_q == {scale_width{1'b1}});
`else
  assign nan_blk = 1'b0;
`endif

  always_comb begin
    o_ready = 1'b0;
    o_valid = 1'b0;
    o_last  = 1'b0;
    o_nan   = 1'b0;
    o_exps  = '0;
    if (!i_rst) begin
      o_ready = ready;
      o_valid = (state_q == STREAM);
      o_last  = is_last;
      if (state_q == STREAM) begin
        o_nan  = nan_blk;
        o_exps = nan_blk ? '1 : restored;
      end
    end
  end

endmodule

// File: tb/tb_mx_scale_expand.sv
// Randomized bench for mx_scale_expand against a plain-arithmetic exponent model.
module tb_mx_scale_expand;

  localparam int L = 32;
  localparam int N = 4;
  localparam int B = L / N;
`ifdef MX_NAN_SCALE_EN
  localparam bit NAN_EN = 1'b1;
`else
  localparam bit NAN_EN = 1'b0;
`endif

  typedef logic [L-1:0][3:0] blk_t;

  logic                clk = 1'b0;
  logic                rst, ivalid, iready;
  logic [7:0]          scale;
  blk_t                exps;
  logic                oready, ovalid, olast, onan;
  logic [N-1:0][7:0]   oexps;
  logic                oready5, ovalid5, olast5, onan5;
  logic [N-1:0][4:0]   oexps5;

  int vec = 0;
  int bad = 0;

  logic [7:0] got  [L];
  logic [4:0] got5 [L];
  bit         gl   [B];
  bit         gn   [B];
  int         nb;

  always #5 clk = ~clk;

  mx_scale_expand dut (
    .i_clk(clk), .i_rst(rst), .i_valid(ivalid), .o_ready(oready), .i_scale(scale),
    .i_exps(exps), .o_valid(ovalid), .i_ready(iready), .o_exps(oexps),
    .o_last(olast), .o_nan(onan)
  );

  mx_scale_expand #(.out_width(5)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_valid(ivalid), .o_ready(oready5), .i_scale(scale),
    .i_exps(exps), .o_valid(ovalid5), .i_ready(iready), .o_exps(oexps5),
    .o_last(olast5), .o_nan(onan5)
  );

  function automatic int ref_exp(int e, int s, int ow);
    int mx;
    int v;
    mx = (1 << ow) - 1;
    if (NAN_EN && s == 255) return mx;
    if (e == 0) return 0;
    v = e + s - 127;
    if (v <= 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  function automatic bit ref_nan(int s);
    return NAN_EN && (s == 255);
  endfunction

  task automatic send(input logic [7:0] s, input blk_t e, output bit to);
    int c;
    c = 0;
    to = 1'b0;
    scale = s;
    exps = e;
    ivalid = 1'b1;
    #1;
    while (!oready) begin
      @(posedge clk); #2;
      c++;
      if (c > 100) begin to = 1'b1; break; end
    end
    @(posedge clk); #2;
    ivalid = 1'b0;
  endtask

  // records every handshaken beat of one block from both instances
  task automatic collect(input int stall_pct, output bit to);
    int cyc;
    cyc = 0;
    nb = 0;
    to = 1'b0;
    while (nb < B) begin
      iready = ($urandom_range(99) >= stall_pct);
      #1;
      if (ovalid && iready) begin
        for (int k = 0; k < N; k++) begin
          got[nb*N+k]  = oexps[k];
          got5[nb*N+k] = oexps5[k];
        end
        gl[nb] = olast;
        gn[nb] = onan;
        nb++;
      end
      @(posedge clk); #2;
      cyc++;
      if (cyc > 300) begin to = 1'b1; break; end
    end
    iready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ivalid = 1'b0; iready = 1'b0; scale = '0; exps = '0;
    repeat (3) @(posedge clk);
    #2;
    ivalid = 1'b1;
    #1;
    vec++; if (oready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b expected 0", oready); end
    vec++; if (ovalid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", ovalid); end
    vec++; if (oexps !== '0) begin bad++; $display("FAIL reset_exps: got %h expected 0", oexps); end
    vec++; if ({olast, onan} !== 2'b00) begin bad++; $display("FAIL reset_last_nan: got %b expected 00", {olast, onan}); end
    ivalid = 1'b0;
    rst = 1'b0;
    #1;
    vec++; if (oready !== 1'b1) begin bad++; $display("FAIL release_ready: got %b expected 1", oready); end
    @(posedge clk); #2;
  endtask

  task automatic test_identity();
    blk_t e;
    bit to;
    for (int i = 0; i < L; i++) e[i] = 4'(i % 16);
    send(8'd127, e, to);
    vec++; if (to) begin bad++; $display("FAIL ident_accept: got timeout expected accept"); end
    vec++; if (ovalid !== 1'b1) begin bad++; $display("FAIL ident_latency: got %b expected 1", ovalid); end
    collect(0, to);
    vec++; if (to) begin bad++; $display("FAIL ident_beats: got %0d expected %0d", nb, B); end
    for (int i = 0; i < L; i++) begin
      vec++;
      if (got[i] !== 8'(i % 16))
        begin bad++; $display("FAIL ident_elem%0d: got %0d expected %0d", i, got[i], i % 16); end
    end
    for (int b = 0; b < B; b++) begin
      vec++;
      if (gl[b] !== (b == B - 1)) begin bad++; $display("FAIL ident_last%0d: got %b expected %b", b, gl[b], b == B - 1); end
    end
  endtask

  task automatic test_arith();
    logic [7:0] s;
    blk_t e;
    bit to;
    int fix_s[3] = '{130, 100, 150};
    int fix_e[3] = '{15, 3, 15};
    for (int t = 0; t < 9; t++) begin
      if (t < 3) begin
        s = 8'(fix_s[t]);
        for (int i = 0; i < L; i++) e[i] = 4'(fix_e[t]);
      end else begin
        s = 8'($urandom_range(255));
        for (int i = 0; i < L; i++) e[i] = 4'($urandom_range(15));
      end
      send(s, e, to);
      vec++; if (to) begin bad++; $display("FAIL arith_accept%0d: got timeout expected accept", t); end
      collect((t < 3) ? 0 : 30, to);
      vec++; if (to) begin bad++; $display("FAIL arith_beats%0d: got %0d expected %0d", t, nb, B); end
      for (int i = 0; i < L; i++) begin
        vec++;
        if (got[i] !== 8'(ref_exp(int'(e[i]), int'(s), 8)))
          begin bad++; $display("FAIL arith8 s=%0d e=%0d: got %0d expected %0d", s, e[i], got[i], ref_exp(int'(e[i]), int'(s), 8)); end
        vec++;
        if (got5[i] !== 5'(ref_exp(int'(e[i]), int'(s), 5)))
          begin bad++; $display("FAIL arith5 s=%0d e=%0d: got %0d expected %0d", s, e[i], got5[i], ref_exp(int'(e[i]), int'(s), 5)); end
      end
      for (int b = 0; b < B; b++) begin
        vec++;
        if (gl[b] !== (b == B - 1) || gn[b] !== ref_nan(int'(s)))
          begin bad++; $display("FAIL arith_flags b%0d: got last=%b nan=%b expected last=%b nan=%b", b, gl[b], gn[b], b == B - 1, ref_nan(int'(s))); end
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] s;
    blk_t e;
    bit to;
    int idx, cyc;
    logic [N-1:0][7:0] held;
    logic hl;
    int pat[4] = '{1, 0, 0, 1};
    s = 8'(120 + $urandom_range(20));
    for (int i = 0; i < L; i++) e[i] = 4'($urandom_range(15));
    send(s, e, to);
    vec++; if (to) begin bad++; $display("FAIL stall_accept: got timeout expected accept"); end
    idx = 0; cyc = 0; held = '0; hl = 1'b0;
    while (idx < B && cyc < 100) begin
      iready = (pat[cyc % 4] != 0);
      #1;
      vec++;
      if (ovalid !== 1'b1) begin bad++; $display("FAIL stall_valid c%0d: got %b expected 1", cyc, ovalid); end
      else begin
        for (int k = 0; k < N; k++) begin
          vec++;
          if (oexps[k] !== 8'(ref_exp(int'(e[idx*N+k]), int'(s), 8)))
            begin bad++; $display("FAIL stall_data beat%0d lane%0d: got %0d expected %0d", idx, k, oexps[k], ref_exp(int'(e[idx*N+k]), int'(s), 8)); end
        end
        vec++;
        if (olast !== (idx == B - 1)) begin bad++; $display("FAIL stall_last beat%0d: got %b expected %b", idx, olast, idx == B - 1); end
        if ((cyc % 4) == 2 || (cyc % 4) == 3) begin
          vec++;
          if (oexps !== held || olast !== hl) begin bad++; $display("FAIL stall_hold c%0d: got %h expected %h", cyc, oexps, held); end
        end
        held = oexps;
        hl = olast;
      end
      if (iready) idx++;
      @(posedge clk); #2;
      cyc++;
    end
    iready = 1'b0;
    vec++; if (idx != B) begin bad++; $display("FAIL stall_beats: got %0d expected %0d", idx, B); end
    vec++; if (ovalid !== 1'b0) begin bad++; $display("FAIL stall_idle: got %b expected 0", ovalid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sa, sb, sx;
    blk_t ea, eb, ex;
    int acc, blk, bt;
    bit er;
    sa = 8'(110 + $urandom_range(30));
    sb = 8'(110 + $urandom_range(30));
    for (int i = 0; i < L; i++) begin
      ea[i] = 4'($urandom_range(15));
      eb[i] = 4'($urandom_range(15));
    end
    acc = 0;
    for (int t = 0; t < 18; t++) begin
      scale  = (acc == 0) ? sa : sb;
      exps   = (acc == 0) ? ea : eb;
      ivalid = (acc < 2);
      iready = 1'b1;
      #1;
      er = (t == 0) || (t == 8) || (t >= 16);
      vec++; if (oready !== er) begin bad++; $display("FAIL b2b_ready t%0d: got %b expected %b", t, oready, er); end
      if (t >= 1 && t <= 16) begin
        vec++;
        if (ovalid !== 1'b1) begin bad++; $display("FAIL b2b_valid t%0d: got %b expected 1", t, ovalid); end
        blk = (t - 1) / B;
        bt  = (t - 1) % B;
        sx  = (blk == 0) ? sa : sb;
        ex  = (blk == 0) ? ea : eb;
        for (int k = 0; k < N; k++) begin
          vec++;
          if (oexps[k] !== 8'(ref_exp(int'(ex[bt*N+k]), int'(sx), 8)))
            begin bad++; $display("FAIL b2b_data t%0d lane%0d: got %0d expected %0d", t, k, oexps[k], ref_exp(int'(ex[bt*N+k]), int'(sx), 8)); end
        end
      end else begin
        vec++;
        if (ovalid !== 1'b0) begin bad++; $display("FAIL b2b_valid t%0d: got %b expected 0", t, ovalid); end
      end
      if (ivalid && oready) acc++;
      @(posedge clk); #2;
    end
    ivalid = 1'b0;
    iready = 1'b0;
    vec++; if (acc != 2) begin bad++; $display("FAIL b2b_accepts: got %0d expected 2", acc); end
  endtask

  task automatic test_nan();
    blk_t e;
    bit to;
    for (int i = 0; i < L; i++) e[i] = (i < 16) ? 4'd3 : 4'($urandom_range(1, 15));
    send(8'hFF, e, to);
    vec++; if (to) begin bad++; $display("FAIL nan_accept: got timeout expected accept"); end
    collect(20, to);
    vec++; if (to) begin bad++; $display("FAIL nan_beats: got %0d expected %0d", nb, B); end
    vec++;
    if (got[0] !== (NAN_EN ? 8'hFF : 8'd131)) begin bad++; $display("FAIL nan_elem0: got %0d expected %0d", got[0], NAN_EN ? 255 : 131); end
    for (int i = 0; i < L; i++) begin
      vec++;
      if (got[i] !== 8'(ref_exp(int'(e[i]), 255, 8)))
        begin bad++; $display("FAIL nan_elem%0d: got %0d expected %0d", i, got[i], ref_exp(int'(e[i]), 255, 8)); end
    end
    for (int b = 0; b < B; b++) begin
      vec++;
      if (gn[b] !== NAN_EN) begin bad++; $display("FAIL nan_flag b%0d: got %b expected %b", b, gn[b], NAN_EN); end
    end
  endtask

  task automatic test_reset_mid();
    blk_t e;
    bit to;
    for (int i = 0; i < L; i++) e[i] = 4'($urandom_range(1, 15));
    send(8'd140, e, to);
    vec++; if (to) begin bad++; $display("FAIL rmid_accept: got timeout expected accept"); end
    iready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    iready = 1'b0;
    @(posedge clk); #2;
    vec++; if (ovalid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b expected 0", ovalid); end
    vec++; if (oexps !== '0) begin bad++; $display("FAIL rmid_exps: got %h expected 0", oexps); end
    rst = 1'b0;
    #1;
    vec++; if (oready !== 1'b1) begin bad++; $display("FAIL rmid_ready: got %b expected 1", oready); end
    @(posedge clk); #2;
    for (int i = 0; i < L; i++) e[i] = 4'($urandom_range(15));
    send(8'd127, e, to);
    collect(0, to);
    vec++; if (to) begin bad++; $display("FAIL rmid_beats: got %0d expected %0d", nb, B); end
    for (int i = 0; i < L; i++) begin
      vec++;
      if (got[i] !== 8'(e[i])) begin bad++; $display("FAIL rmid_elem%0d: got %0d expected %0d", i, got[i], e[i]); end
    end
    vec++; if (gl[B-1] !== 1'b1 || gl[0] !== 1'b0) begin bad++; $display("FAIL rmid_last: got %b/%b expected 0/1", gl[0], gl[B-1]); end
  endtask

  initial begin
    rst = 1'b1; ivalid = 1'b0; iready = 1'b0; scale = '0; exps = '0;
    @(posedge clk); #2;
    test_reset();
    test_identity();
    test_arith();
    test_stall();
    test_back_to_back();
    test_nan();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
